// File: rtl/ucsbece154b_icache.sv
// Direct-mapped read-only instruction cache. Hits return data in the same cycle; a miss refills the
// whole block as an in-order burst and forwards the requested word when it arrives. Busy_o holds fetch until then.
module ucsbece154b_icache #(
   parameter int NUM_SETS    = 8,
   parameter int BLOCK_WORDS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ReadEnable_i,
   input  logic [31:0] ReadAddress_i,
   output logic [31:0] Instruction_o,
   output logic        Ready_o,
   output logic        Busy_o,
   output logic        MemReadRequest_o,
   output logic [31:0] MemReadAddress_o,
   input  logic        MemDataReady_i,
   input  logic [31:0] MemDataIn_i
);

   localparam int OFF_W = $clog2(BLOCK_WORDS);
   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int TAG_W = 32 - IDX_W - OFF_W - 2;
   localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(BLOCK_WORDS - 1);

   typedef enum logic [1:0] {IDLE, REQ, REFILL} state_t;
   state_t state;

   logic [31:0]         dataArray [NUM_SETS][BLOCK_WORDS];
   logic [TAG_W-1:0]    tagArray  [NUM_SETS];
   logic [NUM_SETS-1:0] validArray;

   logic [OFF_W-1:0] offset, missOffset, counter;
   logic [IDX_W-1:0] index, missIndex;
   logic [TAG_W-1:0] tag, missTag;
   logic             hit, addrMatch, earlyRestart, unusedByteBits;

   assign offset         = ReadAddress_i[OFF_W+1:2];
   assign index          = ReadAddress_i[OFF_W+2 +: IDX_W];
   assign tag            = ReadAddress_i[31 -: TAG_W];
   assign unusedByteBits = ^ReadAddress_i[1:0];

   assign hit = (state == IDLE) & ReadEnable_i & validArray[index] & (tagArray[index] == tag);

   // Early restart only for the exact word that missed, while fetch is still asking for it.
   assign addrMatch    = ({tag, index, offset} == {missTag, missIndex, missOffset});
   assign earlyRestart = (state == REFILL) & MemDataReady_i & (counter == missOffset)
                         & ReadEnable_i & addrMatch;

   assign Ready_o       = hit | earlyRestart;
   assign Instruction_o = earlyRestart ? MemDataIn_i : dataArray[index][offset];
   assign Busy_o        = ReadEnable_i & ~Ready_o;

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= IDLE;
         validArray       <= '0;
         counter          <= '0;
         missTag          <= '0;
         missIndex        <= '0;
         missOffset       <= '0;
         MemReadRequest_o <= 1'b0;
         MemReadAddress_o <= '0;
      end else begin
         MemReadRequest_o <= 1'b0;
         case (state)
            IDLE: begin
               if (ReadEnable_i && !hit) begin
                  missTag           <= tag;
                  missIndex         <= index;
                  missOffset        <= offset;
                  counter           <= '0;
                  // Invalidate now so a half-written line can never produce a hit.
                  validArray[index] <= 1'b0;
                  MemReadRequest_o  <= 1'b1;
                  MemReadAddress_o  <= {tag, index, {(OFF_W + 2){1'b0}}};
                  state             <= REQ;
               end
            end
            REQ: state <= REFILL;
            REFILL: begin
               if (MemDataReady_i) begin
                  counter <= counter + 1'b1;
                  if (counter == LAST_WORD) begin
                     validArray[missIndex] <= 1'b1;
                     state                 <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Data and tag storage carry no reset; the valid bits alone decide what may hit.
   always_ff @(posedge clk) begin
      if (!reset && state == REFILL && MemDataReady_i) begin
         dataArray[missIndex][counter] <= MemDataIn_i;
         if (counter == LAST_WORD) tagArray[missIndex] <= missTag;
      end
   end

endmodule

// File: tb/tb_ucsbece154b_icache.sv
// Bench for ucsbece154b_icache: directed scenarios plus randomized fetches against a set/tag residency model.
module tb_ucsbece154b_icache;

   localparam int NUM_SETS    = 8;
   localparam int BLOCK_WORDS = 4;

   logic        clk, reset, ReadEnable, MemDataReady;
   logic [31:0] ReadAddress, MemDataIn, Instruction, MemReadAddress;
   logic        Ready, Busy, MemReadRequest;

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] memImg [256];
   bit          modelValid [NUM_SETS];
   int unsigned modelTag   [NUM_SETS];

   int          obsReq, obsReqCycle, obsReady, obsReadyBeat, obsReadyCycle, obsBusyErr, obsCycles;
   logic [31:0] obsReqAddr, obsInstr;

   ucsbece154b_icache #(.NUM_SETS(NUM_SETS), .BLOCK_WORDS(BLOCK_WORDS)) dut (
      .clk              (clk),
      .reset            (reset),
      .ReadEnable_i     (ReadEnable),
      .ReadAddress_i    (ReadAddress),
      .Instruction_o    (Instruction),
      .Ready_o          (Ready),
      .Busy_o           (Busy),
      .MemReadRequest_o (MemReadRequest),
      .MemReadAddress_o (MemReadAddress),
      .MemDataReady_i   (MemDataReady),
      .MemDataIn_i      (MemDataIn)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; ReadEnable = 1'b0; MemDataReady = 1'b0; MemDataIn = '0; ReadAddress = '0;
      step();
      step();
      reset = 1'b0;
      for (int s = 0; s < NUM_SETS; s++) modelValid[s] = 1'b0;
   endtask

   function automatic int set_of(input logic [31:0] a);
      return int'((a / 16) % NUM_SETS);
   endfunction

   function automatic bit model_hit(input logic [31:0] a);
      return modelValid[set_of(a)] && (modelTag[set_of(a)] == a / 128);
   endfunction

   function automatic void model_fill(input logic [31:0] a);
      modelValid[set_of(a)] = 1'b1;
      modelTag[set_of(a)]   = a / 128;
   endfunction

   function automatic logic [31:0] expected_word(input logic [31:0] a);
      return memImg[a[9:2]];
   endfunction

   task automatic observe(input int beat);
      if (MemReadRequest) begin
         obsReq++;
         obsReqAddr  = MemReadAddress;
         obsReqCycle = obsCycles;
      end
      if (Ready) begin
         if (obsReady == 0) begin
            obsReadyBeat  = beat;
            obsReadyCycle = obsCycles;
            obsInstr      = Instruction;
         end
         obsReady++;
      end
      if (Busy !== (ReadEnable & ~Ready)) obsBusyErr++;
      obsCycles++;
   endtask

   // Presents addr from the current cycle, plays memory for one block with 'gap' idle cycles before
   // each beat, and returns at the first cycle after the last beat with the fetch address still applied.
   task automatic fetch_miss(input logic [31:0] addr, input int gap, input int redirAfter,
                             input logic [31:0] redirAddr);
      int base;
      base = int'(addr[9:4]) * BLOCK_WORDS;
      obsReq = 0; obsReqCycle = -1; obsReady = 0; obsReadyBeat = -1; obsReadyCycle = -1;
      obsBusyErr = 0; obsCycles = 0; obsReqAddr = '0; obsInstr = '0;
      ReadEnable = 1'b1; ReadAddress = addr; MemDataReady = 1'b0;
      #1 observe(-1);
      step();
      #1 observe(-1);
      step();
      for (int k = 0; k < BLOCK_WORDS; k++) begin
         repeat (gap) begin
            MemDataReady = 1'b0;
            #1 observe(-1);
            step();
         end
         MemDataReady = 1'b1;
         MemDataIn    = memImg[base + k];
         #1 observe(k);
         step();
         if (k == redirAfter) ReadAddress = redirAddr;
      end
      MemDataReady = 1'b0;
      MemDataIn    = '0;
   endtask

   task automatic test_reset();
      do_reset();
      ReadEnable = 1'b1; ReadAddress = 32'h0;
      #1;
      vectors++; if (Ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b want 0", Ready); end
      vectors++; if (Busy !== 1'b1) begin miscompares++; $display("FAIL reset_busy_re1 got %b want 1", Busy); end
      vectors++; if (MemReadRequest !== 1'b0) begin miscompares++; $display("FAIL reset_req got %b want 0", MemReadRequest); end
      vectors++; if (MemReadAddress !== 32'h0) begin miscompares++; $display("FAIL reset_req_addr got %h want 0", MemReadAddress); end
      ReadEnable = 1'b0;
      #1;
      vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy_re0 got %b want 0", Busy); end
      step();
   endtask

   task automatic test_cold_miss();
      memImg[0] = 32'h11; memImg[1] = 32'h22; memImg[2] = 32'h33; memImg[3] = 32'h44;
      do_reset();
      fetch_miss(32'h0, 0, -1, 32'h0);
      vectors++; if (obsReq !== 1) begin miscompares++; $display("FAIL cold_req_count got %0d want 1", obsReq); end
      vectors++; if (obsReqAddr !== 32'h0) begin miscompares++; $display("FAIL cold_req_addr got %h want 0", obsReqAddr); end
      vectors++; if (obsReqCycle !== 1) begin miscompares++; $display("FAIL cold_req_cycle got %0d want 1", obsReqCycle); end
      vectors++; if (obsReady !== 1 || obsReadyBeat !== 0) begin miscompares++; $display("FAIL cold_ready got count %0d beat %0d want 1/0", obsReady, obsReadyBeat); end
      vectors++; if (obsInstr !== 32'h11) begin miscompares++; $display("FAIL cold_instr got %h want 11", obsInstr); end
      vectors++; if (obsBusyErr !== 0) begin miscompares++; $display("FAIL cold_busy got %0d errors want 0", obsBusyErr); end
      model_fill(32'h0);
      for (int w = 0; w < BLOCK_WORDS; w++) begin
         ReadAddress = 32'(w * 4);
         #1;
         vectors++;
         if ({Ready, Instruction} !== {1'b1, expected_word(ReadAddress)}) begin
            miscompares++; $display("FAIL cold_hit_%0d got %b/%h want 1/%h", w, Ready, Instruction, expected_word(ReadAddress));
         end
         step();
      end
   endtask

   task automatic test_critical_word();
      do_reset();
      fetch_miss(32'h18, 0, -1, 32'h0);
      vectors++; if (obsReqAddr !== 32'h10 || obsReq !== 1) begin miscompares++; $display("FAIL crit_req got %h x%0d want 10 x1", obsReqAddr, obsReq); end
      vectors++; if (obsReady !== 1 || obsReadyBeat !== 2) begin miscompares++; $display("FAIL crit_ready got count %0d beat %0d want 1/2", obsReady, obsReadyBeat); end
      vectors++; if (obsReadyCycle !== 4) begin miscompares++; $display("FAIL crit_stall got %0d want 4", obsReadyCycle); end
      vectors++; if (obsInstr !== memImg[6]) begin miscompares++; $display("FAIL crit_instr got %h want %h", obsInstr, memImg[6]); end
      vectors++; if (obsBusyErr !== 0) begin miscompares++; $display("FAIL crit_busy got %0d errors want 0", obsBusyErr); end
      model_fill(32'h18);
      step();
   endtask

   task automatic test_conflict();
      do_reset();
      fetch_miss(32'h0, 0, -1, 32'h0);
      model_fill(32'h0);
      fetch_miss(32'h80, 0, -1, 32'h0);
      vectors++; if (obsReq !== 1 || obsReqAddr !== 32'h80) begin miscompares++; $display("FAIL conflict_req got %h x%0d want 80 x1", obsReqAddr, obsReq); end
      vectors++; if (obsReadyBeat !== 0 || obsInstr !== memImg[32]) begin miscompares++; $display("FAIL conflict_instr got beat %0d %h want 0 %h", obsReadyBeat, obsInstr, memImg[32]); end
      model_fill(32'h80);
      fetch_miss(32'h0, 0, -1, 32'h0);
      vectors++; if (obsReq !== 1 || obsReqAddr !== 32'h0) begin miscompares++; $display("FAIL conflict_evict_req got %h x%0d want 0 x1", obsReqAddr, obsReq); end
      vectors++; if (obsReadyBeat !== 0 || obsInstr !== memImg[0]) begin miscompares++; $display("FAIL conflict_refetch got beat %0d %h want 0 %h", obsReadyBeat, obsInstr, memImg[0]); end
      model_fill(32'h0);
      step();
   endtask

   task automatic test_redirect();
      do_reset();
      fetch_miss(32'h20, 0, 1, 32'h44);
      vectors++; if (obsReady !== 1 || obsReadyBeat !== 0) begin miscompares++; $display("FAIL redir_ready got count %0d beat %0d want 1/0", obsReady, obsReadyBeat); end
      model_fill(32'h20);
      fetch_miss(32'h44, 0, -1, 32'h0);
      vectors++; if (obsReq !== 1 || obsReqAddr !== 32'h40 || obsReqCycle !== 1) begin
         miscompares++; $display("FAIL redir_new_miss got %h x%0d at %0d want 40 x1 at 1", obsReqAddr, obsReq, obsReqCycle);
      end
      vectors++; if (obsInstr !== memImg[17]) begin miscompares++; $display("FAIL redir_new_instr got %h want %h", obsInstr, memImg[17]); end
      model_fill(32'h44);
      ReadAddress = 32'h2C;
      #1;
      vectors++; if ({Ready, Instruction} !== {1'b1, memImg[11]}) begin miscompares++; $display("FAIL redir_line2_hit got %b/%h want 1/%h", Ready, Instruction, memImg[11]); end
      step();
   endtask

   task automatic test_reset_mid_refill();
      do_reset();
      ReadEnable = 1'b1; ReadAddress = 32'h0;
      step();
      step();
      for (int k = 0; k < 2; k++) begin
         MemDataReady = 1'b1; MemDataIn = 32'hDEAD_0000 + 32'(k);
         step();
      end
      reset = 1'b1; MemDataReady = 1'b0; ReadEnable = 1'b0;
      step();
      reset = 1'b0;
      for (int k = 2; k < 4; k++) begin
         MemDataReady = 1'b1; MemDataIn = 32'hDEAD_0000 + 32'(k);
         #1;
         vectors++; if ({Ready, MemReadRequest} !== 2'b00) begin miscompares++; $display("FAIL rst_stray_%0d got ready %b req %b want 0/0", k, Ready, MemReadRequest); end
         vectors++; if (MemReadAddress !== 32'h0) begin miscompares++; $display("FAIL rst_stray_addr_%0d got %h want 0", k, MemReadAddress); end
         step();
      end
      MemDataReady = 1'b0;
      for (int s = 0; s < NUM_SETS; s++) modelValid[s] = 1'b0;
      ReadEnable = 1'b1;
      for (int s = 0; s < NUM_SETS; s++) begin
         ReadAddress = 32'(s * 16);
         #1;
         vectors++; if (Ready !== 1'b0) begin miscompares++; $display("FAIL rst_line_%0d_valid got %b want 0", s, Ready); end
      end
      ReadEnable = 1'b0;
      step();
      fetch_miss(32'h0, 0, -1, 32'h0);
      vectors++; if (obsReq !== 1 || obsReqAddr !== 32'h0) begin miscompares++; $display("FAIL rst_refetch_req got %h x%0d want 0 x1", obsReqAddr, obsReq); end
      vectors++; if (obsInstr !== memImg[0]) begin miscompares++; $display("FAIL rst_refetch_instr got %h want %h", obsInstr, memImg[0]); end
      model_fill(32'h0);
      step();
   endtask

   task automatic test_stalled_memory();
      do_reset();
      fetch_miss(32'h34, 3, -1, 32'h0);
      vectors++; if (obsReq !== 1 || obsReqAddr !== 32'h30) begin miscompares++; $display("FAIL stall_req got %h x%0d want 30 x1", obsReqAddr, obsReq); end
      vectors++; if (obsReadyBeat !== 1 || obsReadyCycle !== 9) begin miscompares++; $display("FAIL stall_ready got beat %0d cycle %0d want 1/9", obsReadyBeat, obsReadyCycle); end
      vectors++; if (obsInstr !== memImg[13]) begin miscompares++; $display("FAIL stall_instr got %h want %h", obsInstr, memImg[13]); end
      model_fill(32'h34);
      for (int w = 0; w < BLOCK_WORDS; w++) begin
         ReadAddress = 32'h30 + 32'(w * 4);
         #1;
         vectors++;
         if ({Ready, Instruction} !== {1'b1, expected_word(ReadAddress)}) begin
            miscompares++; $display("FAIL stall_hit_%0d got %b/%h want 1/%h", w, Ready, Instruction, expected_word(ReadAddress));
         end
         step();
      end
   endtask

   task automatic test_random();
      logic [31:0] addr;
      int          gap, beat;
      do_reset();
      for (int i = 0; i < 120; i++) begin
         addr = 32'($urandom_range(0, 255)) * 4;
         if ($urandom_range(0, 9) == 0) begin
            ReadEnable = 1'b0; ReadAddress = addr;
            #1;
            vectors++; if ({Ready, Busy} !== 2'b00) begin miscompares++; $display("FAIL rand_idle_%0d got %b%b want 00", i, Ready, Busy); end
            step();
         end else if (model_hit(addr)) begin
            ReadEnable = 1'b1; ReadAddress = addr;
            #1;
            vectors++;
            if ({Ready, Busy, Instruction} !== {2'b10, expected_word(addr)}) begin
               miscompares++; $display("FAIL rand_hit_%0d addr %h got %b%b/%h want 10/%h", i, addr, Ready, Busy, Instruction, expected_word(addr));
            end
            step();
         end else begin
            gap  = int'($urandom_range(0, 2));
            beat = int'(addr[3:2]);
            fetch_miss(addr, gap, -1, 32'h0);
            vectors++;
            if (obsReq !== 1 || obsReqAddr !== (addr & ~32'hF) || obsReqCycle !== 1) begin
               miscompares++; $display("FAIL rand_req_%0d addr %h got %h x%0d at %0d want %h x1 at 1", i, addr, obsReqAddr, obsReq, obsReqCycle, addr & ~32'hF);
            end
            vectors++;
            if (obsReady !== 1 || obsReadyBeat !== beat || obsReadyCycle !== 2 + beat * (gap + 1) + gap) begin
               miscompares++; $display("FAIL rand_restart_%0d addr %h got x%0d beat %0d cycle %0d want x1 beat %0d cycle %0d",
                                       i, addr, obsReady, obsReadyBeat, obsReadyCycle, beat, 2 + beat * (gap + 1) + gap);
            end
            vectors++;
            if (obsInstr !== expected_word(addr) || obsBusyErr !== 0) begin
               miscompares++; $display("FAIL rand_data_%0d addr %h got %h busyerr %0d want %h busyerr 0", i, addr, obsInstr, obsBusyErr, expected_word(addr));
            end
            model_fill(addr);
            #1;
            vectors++;
            if ({Ready, Instruction} !== {1'b1, expected_word(addr)}) begin
               miscompares++; $display("FAIL rand_after_fill_%0d addr %h got %b/%h want 1/%h", i, addr, Ready, Instruction, expected_word(addr));
            end
            step();
         end
      end
      ReadEnable = 1'b0;
   endtask

   initial begin
      reset = 1'b1; ReadEnable = 1'b0; ReadAddress = '0; MemDataReady = 1'b0; MemDataIn = '0;
      for (int i = 0; i < 256; i++) memImg[i] = $urandom;
      test_reset();
      test_cold_miss();
      test_critical_word();
      test_conflict();
      test_redirect();
      test_reset_mid_refill();
      test_stalled_memory();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
